// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - oversampling 8N1 UART receiver with optional parity and stretched Rx_VALID
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int VALID_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Rx_serial,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_ERROR,
  output logic       Rx_BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int VW = $clog2(VALID_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [VW-1:0] VALID_LEN = VW'(VALID_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d;
  logic          rx_s_q, rx_s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_err_q, par_err_d;
  logic [7:0]    data_q, data_d;
  logic [VW-1:0] valid_cnt_q, valid_cnt_d;
  logic          err_q, err_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = Rx_serial;
    rx_s_d      = rx_meta_q;
    cnt_d       = bit_end ? '0 : cnt_q + CW'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    data_d      = data_q;
    err_d       = 1'b0;
    valid_cnt_d = (valid_cnt_q != '0) ? valid_cnt_q - VW'(1) : '0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        // Re-check the start bit at its centre so short glitches are dropped silently.
        if (cnt_q == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          par_err_d = 1'b0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          par_err_d = rx_s_q ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!rx_s_q) begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end else if (par_err_q) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            data_d      = shift_q;
            valid_cnt_d = VALID_LEN;
            state_d     = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        // Hold off until the line is released so a stuck-low line cannot spawn frames.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_err_q   <= 1'b0;
      data_q      <= 8'h00;
      valid_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_err_q   <= par_err_d;
      data_q      <= data_d;
      valid_cnt_q <= valid_cnt_d;
      err_q       <= err_d;
    end
  end

  assign Rx_DATA  = data_q;
  assign Rx_VALID = (valid_cnt_q != '0);
  assign Rx_ERROR = err_q;
  assign Rx_BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed bench for uart_rx_byte with frame-level expected-event model
module tb_uart_rx_byte;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser      [2];
  logic [7:0] rx_data  [2];
  logic       rx_valid [2];
  logic       rx_error [2];
  logic       rx_busy  [2];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [8:0] exp_mem [2][16];
  int         wr [2];
  int         rd [2];
  logic [7:0] model_data [2];
  logic       v_prev [2];
  logic       e_prev [2];
  int         vrun [2];
  int         lat_start [2];
  logic       lat_chk [2];

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .VALID_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .Rx_serial(ser[0]), .Rx_DATA(rx_data[0]),
    .Rx_VALID(rx_valid[0]), .Rx_ERROR(rx_error[0]), .Rx_BUSY(rx_busy[0])
  );

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .VALID_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .Rx_serial(ser[1]), .Rx_DATA(rx_data[1]),
    .Rx_VALID(rx_valid[1]), .Rx_ERROR(rx_error[1]), .Rx_BUSY(rx_busy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic expect_ev(input int d, input logic err, input logic [7:0] b);
    exp_mem[d][wr[d] % 16] = {err, b};
    wr[d]++;
  endtask

  task automatic check_dut(input int d, input logic v, input logic e, input logic [7:0] data);
    logic [8:0] ent;
    chk($sformatf("dut%0d valid_and_error", d), int'(v && e), 0);
    if (v && !v_prev[d]) begin
      chk($sformatf("dut%0d valid_expected", d), int'(rd[d] < wr[d]), 1);
      if (rd[d] < wr[d]) begin
        ent = exp_mem[d][rd[d] % 16];
        rd[d]++;
        chk($sformatf("dut%0d valid_on_good_frame", d), int'(ent[8]), 0);
        if (!ent[8]) model_data[d] = ent[7:0];
      end
      if (lat_chk[d]) begin
        vectors++;
        if (cyc - lat_start[d] < 153 || cyc - lat_start[d] > 157) begin
          miscompares++;
          $display("FAIL dut%0d latency: got %0d want 155+-2", d, cyc - lat_start[d]);
        end
        lat_chk[d] = 1'b0;
      end
      vrun[d] = 1;
    end else if (v) begin
      vrun[d]++;
    end
    if (!v && v_prev[d]) chk($sformatf("dut%0d valid_width", d), vrun[d], 2);
    if (e) begin
      chk($sformatf("dut%0d error_expected", d), int'(rd[d] < wr[d]), 1);
      if (rd[d] < wr[d]) begin
        ent = exp_mem[d][rd[d] % 16];
        rd[d]++;
        chk($sformatf("dut%0d error_on_bad_frame", d), int'(ent[8]), 1);
      end
    end
    chk($sformatf("dut%0d rx_data", d), int'(data), int'(model_data[d]));
    v_prev[d] = v;
    e_prev[d] = e;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        model_data[d] = 8'h00;
        v_prev[d]     = 1'b0;
        e_prev[d]     = 1'b0;
        vrun[d]       = 0;
        rd[d]         = wr[d];
        lat_chk[d]    = 1'b0;
      end
    end else begin
      check_dut(0, rx_valid[0], rx_error[0], rx_data[0]);
      check_dut(1, rx_valid[1], rx_error[1], rx_data[1]);
    end
  end

  task automatic hold(input int d, input logic b, input int n);
    ser[d] = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input logic stop,
                            input logic has_par, input logic par);
    hold(d, 1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(d, b[i], CPB);
    if (has_par) hold(d, par, CPB);
    hold(d, stop, CPB);
  endtask

  task automatic check_zero_outputs(input int d, input string tag);
    chk($sformatf("%s dut%0d Rx_DATA", tag, d), int'(rx_data[d]), 0);
    chk($sformatf("%s dut%0d Rx_VALID", tag, d), int'(rx_valid[d]), 0);
    chk($sformatf("%s dut%0d Rx_ERROR", tag, d), int'(rx_error[d]), 0);
    chk($sformatf("%s dut%0d Rx_BUSY", tag, d), int'(rx_busy[d]), 0);
  endtask

  initial begin
    logic [7:0] pat;
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0; rd[d] = 0; model_data[d] = 8'h00; v_prev[d] = 1'b0; e_prev[d] = 1'b0;
      vrun[d] = 0; lat_start[d] = 0; lat_chk[d] = 1'b0; ser[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_zero_outputs(0, "reset");
    check_zero_outputs(1, "reset");
    hold(0, 1'b1, 10);

    // single good byte with latency check
    expect_ev(0, 1'b0, 8'hA5);
    lat_start[0] = cyc;
    lat_chk[0]   = 1'b1;
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0);
    hold(0, 1'b1, 10);
    chk("a5 Rx_DATA literal", int'(rx_data[0]), 'hA5);
    chk("a5 valid seen", int'(lat_chk[0]), 0);

    // back-to-back bytes, no idle gap
    expect_ev(0, 1'b0, 8'h00);
    expect_ev(0, 1'b0, 8'hFF);
    expect_ev(0, 1'b0, 8'h3C);
    send_frame(0, 8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0);
    hold(0, 1'b1, 10);
    chk("b2b Rx_DATA literal", int'(rx_data[0]), 'h3C);
    chk("b2b all events", rd[0], wr[0]);

    // framing error followed by a held-low line
    expect_ev(0, 1'b1, 8'h00);
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    hold(0, 1'b0, 40);
    chk("break Rx_BUSY held", int'(rx_busy[0]), 1);
    chk("break Rx_DATA kept", int'(rx_data[0]), 'h3C);
    hold(0, 1'b1, 4);
    chk("break Rx_BUSY released", int'(rx_busy[0]), 0);
    hold(0, 1'b1, 10);
    expect_ev(0, 1'b0, 8'h12);
    send_frame(0, 8'h12, 1'b1, 1'b0, 1'b0);
    hold(0, 1'b1, 10);
    chk("after break Rx_DATA literal", int'(rx_data[0]), 'h12);

    // 4-cycle glitch on idle line
    hold(0, 1'b0, 4);
    chk("glitch Rx_BUSY rises", int'(rx_busy[0]), 1);
    hold(0, 1'b1, 7);
    chk("glitch Rx_BUSY drops", int'(rx_busy[0]), 0);
    hold(0, 1'b1, 20);

    // even parity on dut1
    expect_ev(1, 1'b0, 8'h07);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    hold(1, 1'b1, 10);
    chk("parity good Rx_DATA literal", int'(rx_data[1]), 'h07);
    expect_ev(1, 1'b1, 8'h00);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    hold(1, 1'b1, 10);
    chk("parity all events", rd[1], wr[1]);

    // reset during data bit 4 of 0x81
    pat = 8'h81;
    hold(0, 1'b0, CPB);
    for (int i = 0; i < 4; i++) hold(0, pat[i], CPB);
    hold(0, pat[4], 6);
    reset  = 1'b1;
    ser[0] = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_zero_outputs(0, "midreset");
    check_zero_outputs(1, "midreset");
    hold(0, 1'b1, 20);
    expect_ev(0, 1'b0, 8'h81);
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0);
    hold(0, 1'b1, 20);
    chk("post-reset Rx_DATA literal", int'(rx_data[0]), 'h81);

    chk("dut0 all events", rd[0], wr[0]);
    chk("dut1 all events", rd[1], wr[1]);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- UART receiver stage feeding the Reed-Solomon byte-framing FSM (Rx_DATA / Rx_VALID consumer).
- Oversamples the asynchronous serial line, recovers 8N1 frames, optionally checks parity, and presents each good byte as a stable Rx_DATA with a multi-cycle Rx_VALID strobe.
- Bad frames raise Rx_ERROR instead of Rx_VALID, so the downstream FSM never sees corrupt bytes.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); minimum 8.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- VALID_CYCLES, 2, width of the Rx_VALID pulse in clk cycles; must be < CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- Rx_serial  input  1  asynchronous UART line; idle high
- Rx_DATA  output  8  last good received byte
- Rx_VALID  output  1  high for VALID_CYCLES cycles per good byte
- Rx_ERROR  output  1  one-cycle pulse on framing or parity error
- Rx_BUSY  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values: Rx_DATA=0, Rx_VALID=0, Rx_ERROR=0, Rx_BUSY=0, both synchronizer flops=1, state=IDLE, all counters=0. Reset mid-frame abandons the frame silently, with no VALID and no ERROR.
- Input path: 2-flop synchronizer on Rx_serial. All decisions use the synchronized value (rx_s).
- Bit timer: counter 0..CLKS_PER_BIT-1, cleared on every state change.
- States and transitions:
  - IDLE: rx_s==0 -> START.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s. If 0 -> DATA; if 1 -> IDLE (glitch rejected, no ERROR).
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), shift in LSB first; bit index 0..7. After bit 7 -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample one bit and compare with the XOR of the data bits (inverted when PARITY_ODD). Store the mismatch flag, then -> STOP.
  - STOP: sample mid stop bit.
    - Sample 1 and no parity mismatch: Rx_DATA <= shift register and Rx_VALID=1 on the next cycle; -> IDLE.
    - Sample 0: Rx_ERROR pulses one cycle; -> BREAK.
    - Parity mismatch with stop=1: Rx_ERROR pulses; -> IDLE.
  - BREAK: wait for rx_s==1, then -> IDLE. Prevents a held-low line from retriggering frames.
- Rx_DATA changes only on a good frame. It holds its value through errors and until the next good frame.
- Rx_VALID stretcher: independent counter keeps Rx_VALID high for exactly VALID_CYCLES cycles. The receiver FSM may already be in IDLE or START during this time. A new good frame cannot complete before the stretch ends, given the VALID_CYCLES constraint.
- Rx_ERROR and Rx_VALID are never high in the same cycle.
- Latency, good frame, PARITY_EN=0: Rx_VALID rises (9.5*CLKS_PER_BIT + 3) ± 2 cycles after the Rx_serial falling edge of the start bit.
- Timing tolerance: mid-bit sampling tolerates ±40% bit-edge jitter. No resynchronisation is done within a frame.
- Back-to-back frames (stop bit immediately followed by the next start bit) must be received with no loss.
- Counter widths: sized by $clog2(CLKS_PER_BIT) and $clog2(VALID_CYCLES+1). No wrap occurs in normal operation.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 8N1 -> Rx_DATA=0xA5, Rx_VALID high exactly 2 cycles, rising 155±2 cycles after the start edge; Rx_ERROR stays 0.
- Back-to-back bytes 0x00, 0xFF, 0x3C with no idle gap -> three Rx_VALID pulses with Rx_DATA 0x00, 0xFF, 0x3C in order; Rx_DATA stable between pulses.
- Frame 0x55 with stop bit forced 0, line then held low for 40 cycles -> one Rx_ERROR pulse, no Rx_VALID, Rx_DATA keeps its previous value, Rx_BUSY high until the line returns high. The next byte 0x12 is received correctly.
- 4-cycle low glitch on an idle line -> no VALID, no ERROR, Rx_BUSY drops within CLKS_PER_BIT/2+3 cycles.
- PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity 1 -> VALID, Rx_DATA=0x07. Send 0x07 with parity 0 -> Rx_ERROR pulse, no VALID.
- Assert reset during data bit 4 of 0x81 -> all outputs 0 the next cycle, no VALID or ERROR for that frame. The following frame 0x81 is received correctly.
